// File: rtl/note_highway_engine.sv
// note_highway_engine: six scrolling note slots with strum judging, hit/miss pulses and scores.
// Build option NOTE_LFSR_EN swaps the external spawn strobe for an internal timed LFSR spawner.
module note_highway_engine #(
   parameter int STEP         = 2,
   parameter int SPAWN_PERIOD = 32,
   parameter int HIT_LO       = 256,
   parameter int HIT_HI       = 280,
   parameter int OFF_MAX      = 300
) (
   input  logic        slowclock,
   input  logic        iRST_n,
   input  logic        run,
   input  logic [5:0]  guitar_in,
   input  logic        spawn_req,
   input  logic [1:0]  spawn_lane,
   output logic [31:0] notes1,
   output logic [31:0] notes2,
   output logic [31:0] notes3,
   output logic        p1_hit,
   output logic        p2_hit,
   output logic        p1_miss,
   output logic        p2_miss,
   output logic [7:0]  p1_score,
   output logic [7:0]  p2_score,
   output logic        spawn_drop
);
   localparam logic [11:0] STEP_W    = 12'(STEP);
   localparam logic [11:0] OFF_MAX_W = 12'(OFF_MAX);
   localparam logic [10:0] HIT_LO_W  = 11'(HIT_LO);
   localparam logic [10:0] HIT_HI_W  = 11'(HIT_HI);

   // guitar lanes are ordered red, green, yellow; slot lane bits are red[4], yellow[3], green[2]
   function automatic int lane_bit(input int l);
      case (l)
         0:       return 4;
         1:       return 2;
         default: return 3;
      endcase
   endfunction

   function automatic logic [15:0] lane_word(input logic [1:0] lane);
      case (lane)
         2'd0:    return 16'h0010;
         2'd1:    return 16'h0008;
         2'd2:    return 16'h0004;
         default: return 16'h0000;
      endcase
   endfunction

   logic [15:0] slot_r    [6];
   logic [15:0] slot_nx_s [6];
   logic [2:0]  wr_ptr_r, wr_ptr_nx_s;
   logic [5:0]  sync1_r, sync2_r, sync3_r, edge_r;
   logic [7:0]  score_r    [2];
   logic [7:0]  score_nx_s [2];
   logic [1:0]  hit_cnt_s  [2];
   logic [1:0]  hit_r, miss_r, hit_s, miss_s;
   logic        drop_r, drop_s;
   logic        found_s;
   logic [10:0] best_off_s;
   logic [2:0]  best_idx_s;
   logic [11:0] sum_s;
   logic [8:0]  score_sum_s;
   logic        spawn_go_s;
   logic [1:0]  spawn_lane_s;

`ifdef NOTE_LFSR_EN
   localparam int CNT_W = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
   logic [CNT_W-1:0] tick_cnt_r;
   logic [7:0]       lfsr_r;
   logic             unused_spawn_s;

   assign unused_spawn_s = ^{spawn_req, spawn_lane};
   assign spawn_go_s     = (tick_cnt_r == CNT_W'(SPAWN_PERIOD - 1));
   assign spawn_lane_s   = (lfsr_r[1:0] == 2'd3) ? 2'd0 : lfsr_r[1:0];

   // Spawn timer and lane LFSR, both frozen while run is low
   always_ff @(posedge slowclock or negedge iRST_n) begin
      if (!iRST_n) begin
         tick_cnt_r <= '0;
         lfsr_r     <= 8'hA5;
      end else if (run) begin
         tick_cnt_r <= spawn_go_s ? '0 : tick_cnt_r + CNT_W'(1);
         lfsr_r     <= {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
      end else begin
         tick_cnt_r <= tick_cnt_r;
         lfsr_r     <= lfsr_r;
      end
   end
`else
   assign spawn_go_s   = spawn_req;
   assign spawn_lane_s = spawn_lane;
`endif

   // Next-state: judge on pre-advance offsets, then advance/retire, then spawn into the freed field
   always_comb begin
      for (int k = 0; k < 6; k++) slot_nx_s[k] = slot_r[k];
      wr_ptr_nx_s   = wr_ptr_r;
      hit_s         = 2'b00;
      miss_s        = 2'b00;
      drop_s        = 1'b0;
      hit_cnt_s[0]  = 2'd0;
      hit_cnt_s[1]  = 2'd0;
      score_nx_s[0] = score_r[0];
      score_nx_s[1] = score_r[1];
      found_s       = 1'b0;
      best_off_s    = 11'd0;
      best_idx_s    = 3'd0;
      sum_s         = 12'd0;
      score_sum_s   = 9'd0;
      if (run) begin
         for (int p = 0; p < 2; p++) begin
            for (int l = 0; l < 3; l++) begin
               found_s    = 1'b0;
               best_off_s = 11'd0;
               best_idx_s = 3'd0;
               for (int k = 0; k < 6; k++) begin
                  // strict '>' keeps the lowest index on equal offsets
                  if (slot_r[k][lane_bit(l)] && !slot_r[k][1 - p] &&
                      (slot_r[k][15:5] >= HIT_LO_W) && (slot_r[k][15:5] <= HIT_HI_W) &&
                      (!found_s || (slot_r[k][15:5] > best_off_s))) begin
                     found_s    = 1'b1;
                     best_off_s = slot_r[k][15:5];
                     best_idx_s = 3'(k);
                  end else begin
                     found_s = found_s;
                  end
               end
               if (edge_r[3 * p + l]) begin
                  if (found_s) begin
                     hit_s[p]     = 1'b1;
                     hit_cnt_s[p] = hit_cnt_s[p] + 2'd1;
                     for (int k = 0; k < 6; k++) begin
                        if (best_idx_s == 3'(k)) slot_nx_s[k][1 - p] = 1'b1;
                        else slot_nx_s[k] = slot_nx_s[k];
                     end
                  end else begin
                     miss_s[p] = 1'b1;
                  end
               end else begin
                  miss_s[p] = miss_s[p];
               end
            end
         end
         for (int k = 0; k < 6; k++) begin
            if (|slot_nx_s[k][4:2]) begin
               sum_s = {1'b0, slot_nx_s[k][15:5]} + STEP_W;
               if (sum_s >= OFF_MAX_W) begin
                  miss_s[0]    = miss_s[0] | ~slot_nx_s[k][1];
                  miss_s[1]    = miss_s[1] | ~slot_nx_s[k][0];
                  slot_nx_s[k] = 16'h0000;
               end else begin
                  slot_nx_s[k][15:5] = sum_s[10:0];
               end
            end else begin
               slot_nx_s[k] = 16'h0000;
            end
         end
         if (spawn_go_s && (spawn_lane_s != 2'd3)) begin
            for (int k = 0; k < 6; k++) begin
               if (wr_ptr_r == 3'(k)) begin
                  if (|slot_nx_s[k][4:2]) begin
                     drop_s = 1'b1;
                  end else begin
                     slot_nx_s[k] = lane_word(spawn_lane_s);
                     wr_ptr_nx_s  = (wr_ptr_r == 3'd5) ? 3'd0 : wr_ptr_r + 3'd1;
                  end
               end else begin
                  slot_nx_s[k] = slot_nx_s[k];
               end
            end
         end else begin
            drop_s = 1'b0;
         end
         for (int p = 0; p < 2; p++) begin
            score_sum_s   = {1'b0, score_r[p]} + {7'd0, hit_cnt_s[p]};
            score_nx_s[p] = score_sum_s[8] ? 8'hFF : score_sum_s[7:0];
         end
      end else begin
         hit_s = 2'b00;
      end
   end

   // Two-flop synchronizer plus a third stage for rising-edge detect; edges are dropped while frozen
   always_ff @(posedge slowclock or negedge iRST_n) begin
      if (!iRST_n) begin
         sync1_r <= 6'd0;
         sync2_r <= 6'd0;
         sync3_r <= 6'd0;
         edge_r  <= 6'd0;
      end else begin
         sync1_r <= guitar_in;
         sync2_r <= sync1_r;
         sync3_r <= sync2_r;
         edge_r  <= sync2_r & ~sync3_r & {6{run}};
      end
   end

   // Game state and registered pulses
   always_ff @(posedge slowclock or negedge iRST_n) begin
      if (!iRST_n) begin
         for (int k = 0; k < 6; k++) slot_r[k] <= 16'h0000;
         wr_ptr_r   <= 3'd0;
         score_r[0] <= 8'd0;
         score_r[1] <= 8'd0;
         hit_r      <= 2'b00;
         miss_r     <= 2'b00;
         drop_r     <= 1'b0;
      end else begin
         for (int k = 0; k < 6; k++) slot_r[k] <= slot_nx_s[k];
         wr_ptr_r   <= wr_ptr_nx_s;
         score_r[0] <= score_nx_s[0];
         score_r[1] <= score_nx_s[1];
         hit_r      <= hit_s;
         miss_r     <= miss_s;
         drop_r     <= drop_s;
      end
   end

   assign notes1     = {slot_r[0], slot_r[1]};
   assign notes2     = {slot_r[2], slot_r[3]};
   assign notes3     = {slot_r[4], slot_r[5]};
   assign p1_hit     = hit_r[0];
   assign p2_hit     = hit_r[1];
   assign p1_miss    = miss_r[0];
   assign p2_miss    = miss_r[1];
   assign p1_score   = score_r[0];
   assign p2_score   = score_r[1];
   assign spawn_drop = drop_r;
endmodule

// File: tb/tb_note_highway_engine.sv
// Directed self-checking bench for note_highway_engine (default external-spawn build).
module tb_note_highway_engine;
   logic        slowclock = 1'b0;
   logic        iRST_n;
   logic        run;
   logic [5:0]  guitar_in;
   logic        spawn_req;
   logic [1:0]  spawn_lane;
   logic [31:0] notes1, notes2, notes3;
   logic        p1_hit, p2_hit, p1_miss, p2_miss, spawn_drop;
   logic [7:0]  p1_score, p2_score;
   int          checks_r = 0;
   int          errors_r = 0;
   logic        pulse_seen_r;

   note_highway_engine dut (
      .slowclock  (slowclock),
      .iRST_n     (iRST_n),
      .run        (run),
      .guitar_in  (guitar_in),
      .spawn_req  (spawn_req),
      .spawn_lane (spawn_lane),
      .notes1     (notes1),
      .notes2     (notes2),
      .notes3     (notes3),
      .p1_hit     (p1_hit),
      .p2_hit     (p2_hit),
      .p1_miss    (p1_miss),
      .p2_miss    (p2_miss),
      .p1_score   (p1_score),
      .p2_score   (p2_score),
      .spawn_drop (spawn_drop)
   );

   always #5 slowclock = ~slowclock;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks_r++;
      if (obs !== exp) begin
         errors_r++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge slowclock);
      #1;
   endtask

   task automatic do_reset();
      iRST_n     = 1'b0;
      run        = 1'b0;
      guitar_in  = 6'd0;
      spawn_req  = 1'b0;
      spawn_lane = 2'd0;
      tick();
      tick();
      iRST_n = 1'b1;
      run    = 1'b1;
   endtask

   // red-lane notes every 26 ticks, P1 red strum toggling, until P1 score reaches target
   task automatic play_until(input int target, input int max_ticks);
      int t;
      t = 0;
      while ((int'(p1_score) != target) && (t < max_ticks)) begin
         spawn_req    = (t % 26 == 0);
         spawn_lane   = 2'd0;
         guitar_in[0] = t[0];
         tick();
         t++;
      end
      check_val("play_until_score", {24'd0, p1_score}, target);
      spawn_req = 1'b0;
      guitar_in = 6'd0;
   endtask

   initial begin
      // reset state
      do_reset();
      run = 1'b0;
      check_val("rst_notes1", notes1, 32'h0);
      check_val("rst_notes3", notes3, 32'h0);
      check_val("rst_score", {p1_score, p2_score}, 32'h0);
      check_val("rst_pulses", {p1_hit, p2_hit, p1_miss, p2_miss, spawn_drop}, 32'h0);
      run = 1'b1;

      // spawn red, then scroll
      spawn_req = 1'b1; spawn_lane = 2'd0;
      tick();
      spawn_req = 1'b0;
      check_val("spawn_red", notes1[31:16], 32'h0010);
      repeat (10) tick();
      check_val("offset_20", notes1[31:21], 32'd20);
      check_val("slot0_word", notes1[31:16], 32'h0290);

      // green note hit by P1 at pre-advance offset 258
      do_reset();
      spawn_req = 1'b1; spawn_lane = 2'd2;
      tick();
      spawn_req = 1'b0;
      repeat (126) tick();
      check_val("green_pre_off", notes1[31:21], 32'd252);
      guitar_in[1] = 1'b1;
      repeat (3) tick();
      check_val("hit_not_early", p1_hit, 32'd0);
      tick();
      check_val("p1_hit_pulse", p1_hit, 32'd1);
      check_val("p1_score_1", p1_score, 32'd1);
      check_val("hide_word", notes1[31:16], 32'h2086);
      check_val("p2_hide_clear", notes1[16], 32'd0);
      check_val("p2_score_0", p2_score, 32'd0);
      check_val("no_miss_on_hit", {p1_miss, p2_miss}, 32'd0);
      tick();
      check_val("p1_hit_one_cycle", p1_hit, 32'd0);

      // retire with P2 never hitting
      repeat (18) tick();
      check_val("pre_retire_word", notes1[31:16], 32'h2546);
      check_val("no_early_p2_miss", p2_miss, 32'd0);
      tick();
      check_val("retired_slot", notes1[31:16], 32'h0000);
      check_val("p2_retire_miss", p2_miss, 32'd1);
      check_val("p1_no_retire_miss", p1_miss, 32'd0);
      tick();
      check_val("p2_miss_one_cycle", p2_miss, 32'd0);
      guitar_in = 6'd0;

      // P1 red strum with no red note
      repeat (4) tick();
      guitar_in[0] = 1'b1;
      repeat (3) tick();
      check_val("miss_not_early", p1_miss, 32'd0);
      tick();
      check_val("p1_strum_miss", p1_miss, 32'd1);
      check_val("miss_no_hit", p1_hit, 32'd0);
      check_val("miss_keeps_score", p1_score, 32'd1);
      guitar_in = 6'd0;
      repeat (4) tick();

      // strum and spawn while frozen
      run = 1'b0;
      guitar_in[0] = 1'b1;
      spawn_req = 1'b1; spawn_lane = 2'd1;
      pulse_seen_r = 1'b0;
      repeat (6) begin
         tick();
         pulse_seen_r = pulse_seen_r | p1_miss | p1_hit | p2_miss | p2_hit | spawn_drop;
      end
      spawn_req = 1'b0;
      run = 1'b1;
      repeat (4) begin
         tick();
         pulse_seen_r = pulse_seen_r | p1_miss | p1_hit;
      end
      check_val("frozen_no_pulses", pulse_seen_r, 32'd0);
      check_val("frozen_no_spawn", notes1, 32'h0);
      check_val("frozen_score", p1_score, 32'd1);
      guitar_in = 6'd0;

      // fill all six slots, seventh spawn dropped
      do_reset();
      for (int i = 0; i < 6; i++) begin
         spawn_req  = 1'b1;
         spawn_lane = 2'(i % 3);
         tick();
      end
      check_val("fill_slot0", notes1[31:16], 32'h0150);
      check_val("fill_slot5", notes3[15:0], 32'h0004);
      check_val("fill_no_drop", spawn_drop, 32'd0);
      spawn_lane = 2'd0;
      tick();
      check_val("seventh_drop", spawn_drop, 32'd1);
      check_val("drop_slot0_kept", notes1[31:16], 32'h0190);
      check_val("drop_slot1", notes1[15:0], 32'h0148);
      check_val("drop_slot5", notes3[15:0], 32'h0044);
      spawn_req = 1'b0;
      tick();
      check_val("drop_one_cycle", spawn_drop, 32'd0);
      repeat (142) tick();
      check_val("slot0_at_298", notes1[31:16], 32'h2550);
      // slot0 retires and respawns in the same tick: pointer must still be 0
      spawn_req = 1'b1; spawn_lane = 2'd1;
      tick();
      spawn_req = 1'b0;
      check_val("retire_then_spawn", notes1[31:16], 32'h0008);
      check_val("respawn_no_drop", spawn_drop, 32'd0);

      // three-lane simultaneous hit from score 10
      do_reset();
      play_until(10, 3000);
      repeat (160) tick();
      check_val("field_empty", notes1 | notes2 | notes3, 32'h0);
      for (int i = 0; i < 3; i++) begin
         spawn_req  = 1'b1;
         spawn_lane = 2'(i);
         tick();
      end
      spawn_req = 1'b0;
      repeat (125) tick();
      guitar_in = 6'b000111;
      repeat (4) tick();
      check_val("three_lane_score", p1_score, 32'd13);
      check_val("three_lane_hit", p1_hit, 32'd1);
      check_val("three_lane_no_miss", p1_miss, 32'd0);
      guitar_in = 6'd0;
      repeat (4) tick();

      // saturation at 255
      play_until(255, 20000);
      pulse_seen_r = 1'b0;
      for (int t = 0; t < 400; t++) begin
         spawn_req    = (t % 26 == 0);
         spawn_lane   = 2'd0;
         guitar_in[0] = t[0];
         tick();
         pulse_seen_r = pulse_seen_r | p1_hit;
      end
      check_val("hit_at_255_seen", pulse_seen_r, 32'd1);
      check_val("score_saturated", p1_score, 32'd255);

      $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
      $finish;
   end
endmodule
